// File: rtl/text_string_hasher.sv
// Hashes terminator-delimited text strings, issues one table lookup per string
// and hands the lookup result downstream over a valid/ready port.
module text_string_hasher #(
    parameter logic [7:0]  TERM_CODE      = 8'hFF,
    parameter int unsigned MAX_LEN        = 32,
    parameter int unsigned LOOKUP_TIMEOUT = 64,
    parameter logic [15:0] HASH_INIT      = 16'h1505
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        hash_valid,
    output logic [15:0] hash_in,
    input  logic        lookup_done,
    input  logic        match_found,
    input  logic [7:0]  char_code,
    input  logic [15:0] translation_ptr,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_match,
    output logic [7:0]  res_char_code,
    output logic [15:0] res_trans_ptr,
    output logic [5:0]  res_len,
    output logic        res_overflow,
    output logic        res_timeout
);

    localparam int unsigned LEN_W = 6;
    localparam int unsigned TMR_W = $clog2(LOOKUP_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_ISSUE,
        ST_WAIT,
        ST_RESULT
    } state_t;

    state_t             state;
    logic [15:0]        h;
    logic [LEN_W-1:0]   len;
    logic               ovf;
    logic [TMR_W-1:0]   timer;
    logic [15:0]        h_next_c;
    logic               byte_acc_c;

    // h*33 mod 2^16, then fold in the byte
    assign h_next_c   = 16'((h << 5) + h) ^ {8'h00, byte_data};
    assign byte_acc_c = byte_valid && byte_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_ACCUM;
            h             <= HASH_INIT;
            len           <= '0;
            ovf           <= 1'b0;
            timer         <= '0;
            byte_ready    <= 1'b0;
            hash_valid    <= 1'b0;
            hash_in       <= '0;
            res_valid     <= 1'b0;
            res_match     <= 1'b0;
            res_char_code <= '0;
            res_trans_ptr <= '0;
            res_len       <= '0;
            res_overflow  <= 1'b0;
            res_timeout   <= 1'b0;
        end else begin
            hash_valid <= 1'b0;
            case (state)
                ST_ACCUM: begin
                    byte_ready <= 1'b1;
                    if (byte_acc_c) begin
                        if (byte_data != TERM_CODE) begin
                            if (32'(len) < MAX_LEN) begin
                                h   <= h_next_c;
                                len <= LEN_W'(len + 1'b1);
                            end else begin
                                ovf <= 1'b1;
                            end
                        end else if (ovf) begin
                            // overlong string: report without a lookup
                            byte_ready    <= 1'b0;
                            res_valid     <= 1'b1;
                            res_overflow  <= 1'b1;
                            res_len       <= LEN_W'(MAX_LEN);
                            res_match     <= 1'b0;
                            res_char_code <= '0;
                            res_trans_ptr <= '0;
                            state         <= ST_RESULT;
                        end else if (len != '0) begin
                            byte_ready <= 1'b0;
                            hash_in    <= h;
                            hash_valid <= 1'b1;
                            timer      <= '0;
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    timer <= TMR_W'(timer + 1'b1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer <= TMR_W'(timer + 1'b1);
                    if (lookup_done) begin
                        res_valid     <= 1'b1;
                        res_match     <= match_found;
                        res_char_code <= match_found ? char_code : 8'h00;
                        res_trans_ptr <= match_found ? translation_ptr : 16'h0000;
                        res_len       <= len;
                        state         <= ST_RESULT;
                    end else if (32'(timer) == LOOKUP_TIMEOUT - 1) begin
                        res_valid     <= 1'b1;
                        res_timeout   <= 1'b1;
                        res_match     <= 1'b0;
                        res_char_code <= '0;
                        res_trans_ptr <= '0;
                        res_len       <= len;
                        state         <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid     <= 1'b0;
                        res_match     <= 1'b0;
                        res_char_code <= '0;
                        res_trans_ptr <= '0;
                        res_len       <= '0;
                        res_overflow  <= 1'b0;
                        res_timeout   <= 1'b0;
                        h             <= HASH_INIT;
                        len           <= '0;
                        ovf           <= 1'b0;
                        byte_ready    <= 1'b1;
                        state         <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_text_string_hasher.sv
// Self-checking bench for text_string_hasher: directed cases plus random strings
// checked against a plain-arithmetic hash/length model.
module tb_text_string_hasher;

    localparam int MAX_LEN = 32;
    localparam int TMO     = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        hash_valid;
    logic [15:0] hash_in;
    logic        lookup_done;
    logic        match_found;
    logic [7:0]  char_code;
    logic [15:0] translation_ptr;
    logic        res_valid;
    logic        res_ready;
    logic        res_match;
    logic [7:0]  res_char_code;
    logic [15:0] res_trans_ptr;
    logic [5:0]  res_len;
    logic        res_overflow;
    logic        res_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] str_q[$];

    text_string_hasher dut (
        .clk(clk), .rst_n(rst_n),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .hash_valid(hash_valid), .hash_in(hash_in),
        .lookup_done(lookup_done), .match_found(match_found),
        .char_code(char_code), .translation_ptr(translation_ptr),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_match(res_match), .res_char_code(res_char_code),
        .res_trans_ptr(res_trans_ptr), .res_len(res_len),
        .res_overflow(res_overflow), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // djb2-style hash over the string, 16-bit arithmetic
    function automatic logic [15:0] model_hash();
        int h = 32'h1505;
        foreach (str_q[i]) h = ((h * 33) % 65536) ^ int'(str_q[i]);
        return 16'(h);
    endfunction

    task automatic check_result(input logic m, input logic [7:0] cc, input logic [15:0] tp,
                                input int len, input logic ov, input logic to);
        check("res_valid", res_valid, 1);
        check("res_match", res_match, m);
        check("res_char_code", res_char_code, cc);
        check("res_trans_ptr", res_trans_ptr, tp);
        check("res_len", res_len, len);
        check("res_overflow", res_overflow, ov);
        check("res_timeout", res_timeout, to);
        check("byte_ready_in_result", byte_ready, 0);
    endtask

    task automatic wait_byte_ready();
        int k = 0;
        while (byte_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("byte_ready_wait", byte_ready, 1);
    endtask

    // mode: 0 = match, 1 = no match, 2 = lookup_done never sent
    task automatic run_string(input int mode, input int dly, input int hold,
                              input logic [7:0] cc, input logic [15:0] tp);
        int n = str_q.size();
        logic [15:0] eh = model_hash();
        logic ov = (n > MAX_LEN);
        int elen = ov ? MAX_LEN : n;
        logic em;
        logic [7:0] ecc;
        logic [15:0] etp;
        logic eto;
        wait_byte_ready();
        foreach (str_q[i]) begin
            byte_valid = 1'b1;
            byte_data  = str_q[i];
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        if (n == 0) begin
            check("empty_hash_valid", hash_valid, 0);
            check("empty_res_valid", res_valid, 0);
            check("empty_byte_ready", byte_ready, 1);
            lookup_done = 1'b1;
            match_found = 1'b1;
            @(negedge clk);
            lookup_done = 1'b0;
            repeat (3) @(negedge clk);
            check("empty_no_result", res_valid, 0);
            check("empty_no_hash", hash_valid, 0);
            check("empty_ready_kept", byte_ready, 1);
            return;
        end
        if (ov) begin
            check("ovf_no_hash_valid", hash_valid, 0);
            em = 0; ecc = 0; etp = 0; eto = 0;
        end else begin
            check("hash_valid", hash_valid, 1);
            check("hash_in", hash_in, eh);
            if (mode == 2) begin
                for (int k = 1; k < TMO; k++) begin
                    @(negedge clk);
                    if (k == 1) check("hash_valid_pulse", hash_valid, 0);
                end
                check("no_early_timeout", res_valid, 0);
                check("hash_in_held", hash_in, eh);
                @(negedge clk);
                em = 0; ecc = 0; etp = 0; eto = 1;
            end else begin
                repeat (dly) @(negedge clk);
                check("hash_valid_pulse", hash_valid, 0);
                check("waiting_no_result", res_valid, 0);
                lookup_done     = 1'b1;
                match_found     = (mode == 0);
                char_code       = cc;
                translation_ptr = tp;
                @(negedge clk);
                lookup_done     = 1'b0;
                char_code       = 8'($urandom);
                translation_ptr = 16'($urandom);
                em  = (mode == 0);
                ecc = (mode == 0) ? cc : 8'h00;
                etp = (mode == 0) ? tp : 16'h0000;
                eto = 0;
            end
        end
        check_result(em, ecc, etp, elen, ov, eto);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_result(em, ecc, etp, elen, ov, eto);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_cleared", res_valid, 0);
        check("byte_ready_after_hs", byte_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        lookup_done = 1'b0; match_found = 1'b0; char_code = 8'h00;
        translation_ptr = 16'h0000; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_hash_valid", hash_valid, 0);
        check("rst_hash_in", hash_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_fields", {res_match, res_char_code, res_trans_ptr, res_len,
                                 res_overflow, res_timeout}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("byte_ready_after_rst", byte_ready, 1);

        // single byte, match
        str_q = {}; str_q.push_back(8'h41);
        run_string(0, 3, 0, 8'h41, 16'h0100);
        // two bytes, no match with nonzero table data
        str_q = {}; str_q.push_back(8'h41); str_q.push_back(8'h42);
        run_string(1, 5, 0, 8'h5A, 16'hBEEF);
        // empty string
        str_q = {};
        run_string(0, 1, 0, 8'h00, 16'h0000);
        // overflow
        str_q = {}; for (int i = 0; i < 40; i++) str_q.push_back(8'h41);
        run_string(0, 1, 2, 8'h00, 16'h0000);
        // exactly MAX_LEN bytes is not an overflow
        str_q = {}; for (int i = 0; i < MAX_LEN; i++) str_q.push_back(8'(i + 1));
        run_string(0, 2, 0, 8'h33, 16'h1234);
        // timeout, then next string starts from the seed
        str_q = {}; str_q.push_back(8'h41);
        run_string(2, 0, 0, 8'h00, 16'h0000);
        run_string(0, 1, 0, 8'h41, 16'h0100);
        // lookup_done on the last WAIT cycle beats the timeout
        str_q = {}; str_q.push_back(8'h10);
        run_string(0, TMO - 1, 0, 8'h77, 16'h4321);
        // long res_ready stall
        str_q = {}; str_q.push_back(8'h41); str_q.push_back(8'h42);
        run_string(0, 4, 10, 8'h61, 16'hA5A5);

        // reset mid-WAIT aborts the string
        str_q = {}; str_q.push_back(8'h41);
        wait_byte_ready();
        byte_valid = 1'b1; byte_data = 8'h41; @(negedge clk);
        byte_data = 8'hFF; @(negedge clk);
        byte_valid = 1'b0;
        check("pre_rst_hash_valid", hash_valid, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midwait_rst_outputs", {byte_ready, hash_valid, hash_in, res_valid, res_match,
                                      res_char_code, res_trans_ptr, res_len,
                                      res_overflow, res_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        lookup_done = 1'b1; match_found = 1'b1;
        @(negedge clk);
        lookup_done = 1'b0;
        repeat (TMO + 4) @(negedge clk);
        check("no_result_after_rst", res_valid, 0);
        check("no_hash_after_rst", hash_valid, 0);
        run_string(0, 2, 0, 8'h41, 16'h0100);

        // random strings and lookup behaviour
        for (int t = 0; t < 30; t++) begin
            int len = $urandom_range(0, 36);
            int mode = $urandom_range(0, 2);
            str_q = {};
            for (int i = 0; i < len; i++) str_q.push_back(8'($urandom_range(0, 254)));
            run_string(mode, $urandom_range(1, TMO - 1), $urandom_range(0, 3),
                       8'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
